gcd_rr_scheduler: RTL
=====================

// Module: gcd_rr_scheduler
// PURPOSE
// Shares one GCD engine (controller + datapath) between NREQ requesters. It arbitrates
// round-robin, latches the winner's operands and pulses go. It then waits for done,
// returns the result tagged with the requester id, and clears the engine for the next job.
// It sits between the request fabric and the single gcd engine instance.
// PARAMETERS
// NREQ     4     number of requesters (2..8)
// W        8     operand/result width in bits
// TMO_CYC  1023  watchdog limit in engine cycles; must be < 2**16
// PORTS
// clk         in   1        system clock, rising edge
// rst_n       in   1        asynchronous reset, active low
// req_valid   in   NREQ     per-requester job request
// req_a       in   NREQ*W   operand A, requester i at [i*W +: W]
// req_b       in   NREQ*W   operand B, same packing
// req_ready   out  NREQ     one-hot, one-cycle accept pulse to the granted requester
// gcd_go      out  1        one-cycle start pulse to the engine
// gcd_a       out  W        latched operand A to the engine, stable from LAUNCH until CLEAR
// gcd_b       out  W        latched operand B to the engine, stable from LAUNCH until CLEAR
// gcd_done    in   1        engine done; held high until the engine is cleared
// gcd_result  in   W        engine result, valid while gcd_done=1
// gcd_clr     out  1        one-cycle active-high clear that returns the engine to idle
// rsp_valid   out  1        response valid; held until rsp_ready
// rsp_ready   in   1        response consumer ready
// rsp_id      out  3        index of the requester being answered
// rsp_result  out  W        gcd value
// rsp_err     out  1        1 = watchdog timeout; rsp_result=0
// busy        out  1        1 in every state except IDLE
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE, rr_ptr=NREQ-1. All outputs are 0, watchdog=0.
// - FSM: IDLE -> LAUNCH -> WAIT -> RESP -> CLEAR -> IDLE; bypass path IDLE -> RESP.
// - IDLE: winner = first i with req_valid[i]=1, searching from (rr_ptr+1) mod NREQ upward, wrapping.
//   The grant cycle does all of the following:
//   - drive req_ready[winner]=1 for exactly this cycle;
//   - latch operands and id;
//   - set rr_ptr=winner.
//   Requesters must hold a/b stable while valid; a request is consumed only on req_ready.
// - Zero operand: if either latched operand is 0 (the engine never terminates on 0):
//   - rsp_result = the other operand; 0 if both are 0;
//   - next state is RESP, skipping the engine (no go, no clr).
// - LAUNCH: gcd_go=1 for one cycle, watchdog cleared; next state is WAIT.
// - WAIT: watchdog increments each cycle.
//   - gcd_done=1: capture gcd_result, rsp_err=0, go to RESP.
//   - Else when watchdog==TMO_CYC: rsp_result=0, rsp_err=1, go to RESP.
//   - done wins if both happen in the same cycle.
// - RESP: rsp_valid=1, rsp_id/rsp_result/rsp_err held.
//   - On rsp_valid&rsp_ready, leave for CLEAR (engine path) or IDLE (bypass).
//   - Unbounded backpressure is allowed; no new grant while in RESP.
// - CLEAR: gcd_clr=1 for one cycle; next state is IDLE, and a new grant is possible the following cycle.
// - Latency: grant to gcd_go = 1 cycle; gcd_done to rsp_valid = 1 cycle; bypass grant to rsp_valid = 1 cycle.
// - Throughput: at most one job in flight; req_ready is never asserted when busy=1.
// - Any req_valid that drops before grant is ignored; no state is kept per requester.
// - Reset mid-job aborts immediately:
//   - no response is issued and req_ready, rsp_valid and gcd_go all drop asynchronously;
//   - gcd_clr=1 is driven in the first post-reset cycle only if gcd_done=1, so the engine is recovered.
// TESTING
// 1) Single job: req_valid=4'b0001, a=36, b=24.
//    -> req_ready=0001 pulse, gcd_go 1 cycle later;
//    -> model done after 10 cycles with result 12: rsp_valid, id=0, result=12, err=0;
//    -> gcd_clr 1 cycle after the rsp handshake.
// 2) Round robin: req_valid=4'b1111 held with rsp_ready=1.
//    -> grant order is 0,1,2,3,0; each requester gets exactly one grant per 4 jobs.
// 3) Bypass: a=0, b=45 -> rsp_result=45, with no gcd_go and no gcd_clr.
//    a=0, b=0 -> rsp_result=0, err=0.
// 4) Backpressure: rsp_ready=0 for 20 cycles during a response.
//    -> rsp_* stable, busy=1, no req_ready; the job completes on the first rsp_ready=1.
// 5) Watchdog: model never asserts done, TMO_CYC=15.
//    -> rsp_valid with err=1, result=0 exactly 15 WAIT cycles after gcd_go;
//    -> then gcd_clr pulses.
// 6) Reset mid-WAIT with gcd_done=1 already high.
//    -> all outputs 0 during reset, gcd_clr pulse after release;
//    -> next request granted to index 0.

Source files
------------

// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end sharing one GCD engine between NREQ requesters.
// Grants one job at a time, launches the engine (or short-circuits zero operands) and returns a tagged result.
module gcd_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int TMO_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              gcd_go,
  output logic [W-1:0]      gcd_a,
  output logic [W-1:0]      gcd_b,
  input  logic              gcd_done,
  input  logic [W-1:0]      gcd_result,
  output logic              gcd_clr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2:0]        rsp_id,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, RESP, CLEAR} state_t;

  state_t        state, state_nxt;
  logic          boot;
  logic [2:0]    rr_ptr;
  logic          bypass;
  logic [15:0]   wd;
  logic [15:0]   wd_nxt;
  logic          tmo_hit;
  logic          win_found;
  logic [2:0]    win_idx;
  logic [W-1:0]  win_a;
  logic [W-1:0]  win_b;
  logic          win_zero;
  logic          grant;

  // Rotating priority search starting just after the last winner; smallest distance wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_a     = '0;
    win_b     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if ((i == (int'(rr_ptr) + k) % NREQ) && req_valid[i]) begin
          win_found = 1'b1;
          win_idx   = 3'(i);
          win_a     = req_a[i*W +: W];
          win_b     = req_b[i*W +: W];
        end
      end
    end
  end

  // The cycle right after reset is reserved for recovering an engine left in done.
  assign grant    = (state == IDLE) && !boot && win_found;
  assign win_zero = (win_a == '0) || (win_b == '0);

  // Timeout fires on the TMO_CYC-th WAIT cycle after the launch pulse.
  assign wd_nxt  = wd + 16'd1;
  assign tmo_hit = (wd_nxt == 16'(TMO_CYC));

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = grant && (win_idx == 3'(i));
    end
  end

  assign gcd_go    = (state == LAUNCH);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign gcd_clr   = (state == CLEAR) || (boot && gcd_done && rst_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      boot  <= 1'b1;
    end else begin
      state <= state_nxt;
      boot  <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt = win_zero ? RESP : LAUNCH;
        end
      end
      LAUNCH: state_nxt = WAIT;
      WAIT: begin
        if (gcd_done || tmo_hit) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = bypass ? IDLE : CLEAR;
        end
      end
      CLEAR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= 3'(NREQ - 1);
      gcd_a      <= '0;
      gcd_b      <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      bypass     <= 1'b0;
      wd         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            rr_ptr  <= win_idx;
            gcd_a   <= win_a;
            gcd_b   <= win_b;
            rsp_id  <= win_idx;
            rsp_err <= 1'b0;
            bypass  <= win_zero;
            // gcd(x,0)=x; when A is zero B is the answer, which also covers 0,0.
            if (win_zero) begin
              rsp_result <= (win_a == '0) ? win_b : win_a;
            end
          end
        end
        LAUNCH: wd <= '0;
        WAIT: begin
          wd <= wd_nxt;
          if (gcd_done) begin
            rsp_result <= gcd_result;
            rsp_err    <= 1'b0;
          end else if (tmo_hit) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
